// File: rtl/br_resolve.sv
// br_resolve: branch resolution unit for the pipelined rv32 core.
//
// Resolves conditional branches, JAL and JALR from the comparator flags. It
// compares the result with the fetch-stage prediction and raises a held
// redirect plus a pipeline flush on a mispredict. It also owns the 2-bit
// branch history table that fetch queries, and keeps the branch and
// mispredict counters.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   EXU_i_*                instruction presented for resolution
//   EXU_o_ready            high only in IDLE, and only out of reset
//   BR_JMP_i_br_eq/lt      comparator flags
//   BRU_o_br_un            comparator unsigned select (funct3[1])
//   IFU_i_pc               fetch BHT lookup PC
//   IFU_o_pred_taken       BHT counter MSB for IFU_i_pc
//   IFU_o_redirect_*       redirect request to fetch (valid/ready/pc)
//   BRU_o_flush            flush younger stages
//   BRU_o_taken            resolved direction of the last accepted instruction
//   BRU_o_br_cnt/mis_cnt   accepted / mispredicted counters
module br_resolve #(
  parameter int WIDTH        = 32,
  parameter int BHT_IDX      = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EXU_i_valid,
  output logic             EXU_o_ready,
  input  logic [2:0]       EXU_i_funct3,
  input  logic             EXU_i_is_jal,
  input  logic             EXU_i_is_jalr,
  input  logic [WIDTH-1:0] EXU_i_pc,
  input  logic [WIDTH-1:0] EXU_i_target,
  input  logic             EXU_i_pred_taken,
  input  logic             BR_JMP_i_br_eq,
  input  logic             BR_JMP_i_br_lt,
  output logic             BRU_o_br_un,
  input  logic [WIDTH-1:0] IFU_i_pc,
  output logic             IFU_o_pred_taken,
  output logic             IFU_o_redirect_valid,
  input  logic             IFU_i_redirect_ready,
  output logic [WIDTH-1:0] IFU_o_redirect_pc,
  output logic             BRU_o_flush,
  output logic             BRU_o_taken,
  output logic [CNT_W-1:0] BRU_o_br_cnt,
  output logic [CNT_W-1:0] BRU_o_mis_cnt
);

  localparam int NENT = 1 << BHT_IDX;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t                 state, state_nxt;
  logic [FC_W-1:0]        fl_cnt;
  logic [NENT-1:0][1:0]   bht;

  logic                   accept;
  logic                   jalr_eff;   // JALR only when JAL is not also asserted
  logic                   cond_legal; // conditional branch with a defined funct3
  logic                   legal;
  logic                   taken_c;
  logic                   mispred_c;
  logic [WIDTH-1:0]       redir_pc_c;
  logic [BHT_IDX-1:0]     upd_idx, lkp_idx;

  assign EXU_o_ready      = (state == IDLE) && rst_n;
  assign accept           = EXU_i_valid && EXU_o_ready;
  assign BRU_o_br_un      = EXU_i_funct3[1];
  assign upd_idx          = EXU_i_pc[BHT_IDX+1:2];
  assign lkp_idx          = IFU_i_pc[BHT_IDX+1:2];
  // Lookup reads the registered table, so a same-cycle write is not visible.
  assign IFU_o_pred_taken = bht[lkp_idx][1];

  // Decode and resolve
  always_comb begin
    jalr_eff   = EXU_i_is_jalr && !EXU_i_is_jal;
    // funct3 01x is undefined for branches
    cond_legal = !EXU_i_is_jal && !EXU_i_is_jalr && (EXU_i_funct3[2:1] != 2'b01);
    legal      = EXU_i_is_jal || EXU_i_is_jalr || cond_legal;
    taken_c    = 1'b0;
    if (EXU_i_is_jal || EXU_i_is_jalr) begin
      taken_c = 1'b1;
    end else begin
      case (EXU_i_funct3)
        3'b000:          taken_c = BR_JMP_i_br_eq;
        3'b001:          taken_c = !BR_JMP_i_br_eq;
        3'b100, 3'b110:  taken_c = BR_JMP_i_br_lt;
        3'b101, 3'b111:  taken_c = !BR_JMP_i_br_lt;
        default:         taken_c = 1'b0;
      endcase
    end
    mispred_c  = legal && ((taken_c != EXU_i_pred_taken) || jalr_eff);
    if (taken_c)
      redir_pc_c = jalr_eff ? {EXU_i_target[WIDTH-1:1], 1'b0} : EXU_i_target;
    else
      redir_pc_c = EXU_i_pc + WIDTH'(4);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && mispred_c) state_nxt = REDIRECT;
      REDIRECT: if (IFU_i_redirect_ready) state_nxt = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      FLUSH:    if (fl_cnt == FC_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    IFU_o_redirect_valid = (state == REDIRECT);
    BRU_o_flush          = (state != IDLE);
  end

  // Flush cycle counter: zero on FLUSH entry, counts while in FLUSH
  always_ff @(posedge clk) begin
    if (!rst_n || state != FLUSH) fl_cnt <= '0;
    else                          fl_cnt <= fl_cnt + FC_W'(1);
  end

  // Redirect target, direction and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      IFU_o_redirect_pc <= '0;
      BRU_o_taken       <= 1'b0;
      BRU_o_br_cnt      <= '0;
      BRU_o_mis_cnt     <= '0;
    end else if (accept) begin
      BRU_o_taken <= legal && taken_c;
      if (mispred_c) begin
        IFU_o_redirect_pc <= redir_pc_c;
        BRU_o_mis_cnt     <= BRU_o_mis_cnt + CNT_W'(1);
      end
      if (legal) BRU_o_br_cnt <= BRU_o_br_cnt + CNT_W'(1);
    end
  end

  // Branch history table: 2-bit saturating counters, weakly not-taken at reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) bht[i] <= 2'b01;
    end else if (accept && cond_legal) begin
      if (taken_c && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'b01;
      else if (!taken_c && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'b01;
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
module tb_br_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EXU_i_valid;
  logic        EXU_o_ready;
  logic [2:0]  EXU_i_funct3;
  logic        EXU_i_is_jal, EXU_i_is_jalr;
  logic [31:0] EXU_i_pc, EXU_i_target;
  logic        EXU_i_pred_taken;
  logic        BR_JMP_i_br_eq, BR_JMP_i_br_lt;
  logic        BRU_o_br_un;
  logic [31:0] IFU_i_pc;
  logic        IFU_o_pred_taken;
  logic        IFU_o_redirect_valid;
  logic        IFU_i_redirect_ready;
  logic [31:0] IFU_o_redirect_pc;
  logic        BRU_o_flush, BRU_o_taken;
  logic [31:0] BRU_o_br_cnt, BRU_o_mis_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  br_resolve #(.WIDTH(32), .BHT_IDX(6), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXU_i_valid(EXU_i_valid), .EXU_o_ready(EXU_o_ready),
    .EXU_i_funct3(EXU_i_funct3), .EXU_i_is_jal(EXU_i_is_jal), .EXU_i_is_jalr(EXU_i_is_jalr),
    .EXU_i_pc(EXU_i_pc), .EXU_i_target(EXU_i_target), .EXU_i_pred_taken(EXU_i_pred_taken),
    .BR_JMP_i_br_eq(BR_JMP_i_br_eq), .BR_JMP_i_br_lt(BR_JMP_i_br_lt),
    .BRU_o_br_un(BRU_o_br_un),
    .IFU_i_pc(IFU_i_pc), .IFU_o_pred_taken(IFU_o_pred_taken),
    .IFU_o_redirect_valid(IFU_o_redirect_valid), .IFU_i_redirect_ready(IFU_i_redirect_ready),
    .IFU_o_redirect_pc(IFU_o_redirect_pc),
    .BRU_o_flush(BRU_o_flush), .BRU_o_taken(BRU_o_taken),
    .BRU_o_br_cnt(BRU_o_br_cnt), .BRU_o_mis_cnt(BRU_o_mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] f3, input logic jal, input logic jalr,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                    input logic eq, input logic lt);
    EXU_i_valid = 1'b1; EXU_i_funct3 = f3; EXU_i_is_jal = jal; EXU_i_is_jalr = jalr;
    EXU_i_pc = pc; EXU_i_target = tgt; EXU_i_pred_taken = pred;
    BR_JMP_i_br_eq = eq; BR_JMP_i_br_lt = lt;
    #1;
  endtask

  // Complete a pending redirect immediately and wait out the flush.
  task automatic finish_redirect(input string tag);
    IFU_i_redirect_ready = 1'b1;
    tick();
    IFU_i_redirect_ready = 1'b0;
    tick();
    tick();
    chk({tag, "_ready_back"}, {31'd0, EXU_o_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; EXU_i_valid = 1'b0; EXU_i_funct3 = 3'b000; EXU_i_is_jal = 1'b0;
    EXU_i_is_jalr = 1'b0; EXU_i_pc = '0; EXU_i_target = '0; EXU_i_pred_taken = 1'b0;
    BR_JMP_i_br_eq = 1'b0; BR_JMP_i_br_lt = 1'b0; IFU_i_pc = '0; IFU_i_redirect_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready_low", {31'd0, EXU_o_ready}, 32'd0);
    chk("rst_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("rst_rpc", IFU_o_redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, BRU_o_flush}, 32'd0);
    chk("rst_taken", {31'd0, BRU_o_taken}, 32'd0);
    chk("rst_br_cnt", BRU_o_br_cnt, 32'd0);
    chk("rst_mis_cnt", BRU_o_mis_cnt, 32'd0);
    chk("rst_pred", {31'd0, IFU_o_pred_taken}, 32'd0);
    rst_n = 1'b1; #1;
    chk("rst_ready_high", {31'd0, EXU_o_ready}, 32'd1);

    // beq taken, predicted not taken: full redirect timing
    br(3'b000, 0, 0, 32'h100, 32'h140, 0, 1, 0);
    chk("beq_br_un", {31'd0, BRU_o_br_un}, 32'd0);
    tick(); EXU_i_valid = 1'b0;                       // T+1
    chk("beq_rv", {31'd0, IFU_o_redirect_valid}, 32'd1);
    chk("beq_rpc", IFU_o_redirect_pc, 32'h140);
    chk("beq_flush", {31'd0, BRU_o_flush}, 32'd1);
    chk("beq_taken", {31'd0, BRU_o_taken}, 32'd1);
    chk("beq_br_cnt", BRU_o_br_cnt, 32'd1);
    chk("beq_mis_cnt", BRU_o_mis_cnt, 32'd1);
    chk("beq_ready_t1", {31'd0, EXU_o_ready}, 32'd0);
    IFU_i_pc = 32'h100; #1;
    chk("beq_bht_10", {31'd0, IFU_o_pred_taken}, 32'd1);
    IFU_i_redirect_ready = 1'b1;                      // handshake in T+1
    tick(); IFU_i_redirect_ready = 1'b0;              // T+2
    chk("beq_rv_drop", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("beq_flush_t2", {31'd0, BRU_o_flush}, 32'd1);
    chk("beq_ready_t2", {31'd0, EXU_o_ready}, 32'd0);
    tick();                                           // T+3
    chk("beq_flush_t3", {31'd0, BRU_o_flush}, 32'd1);
    chk("beq_ready_t3", {31'd0, EXU_o_ready}, 32'd0);
    tick();                                           // T+4
    chk("beq_flush_t4", {31'd0, BRU_o_flush}, 32'd0);
    chk("beq_ready_t4", {31'd0, EXU_o_ready}, 32'd1);

    // bltu not taken, correctly predicted: BHT[0x80] 01 -> 00
    IFU_i_pc = 32'h80;
    br(3'b110, 0, 0, 32'h80, 32'h999, 0, 0, 0);
    chk("bltu_br_un", {31'd0, BRU_o_br_un}, 32'd1);
    tick();
    // bltu taken, predicted taken: back-to-back accept, 00 -> 01 (MSB still 0)
    br(3'b110, 0, 0, 32'h80, 32'h900, 1, 0, 1);
    chk("bltu_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("bltu_taken", {31'd0, BRU_o_taken}, 32'd0);
    chk("bltu_ready", {31'd0, EXU_o_ready}, 32'd1);
    tick(); EXU_i_valid = 1'b0; #1;
    chk("bltu2_taken", {31'd0, BRU_o_taken}, 32'd1);
    chk("bltu2_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("bltu_bht_01", {31'd0, IFU_o_pred_taken}, 32'd0);
    chk("bltu_br_cnt", BRU_o_br_cnt, 32'd3);
    chk("bltu_mis_cnt", BRU_o_mis_cnt, 32'd1);

    // jalr predicted taken still redirects, bit 0 cleared
    br(3'b000, 0, 1, 32'h300, 32'h203, 1, 0, 0);
    tick(); EXU_i_valid = 1'b0;
    chk("jalr_rv", {31'd0, IFU_o_redirect_valid}, 32'd1);
    chk("jalr_rpc", IFU_o_redirect_pc, 32'h202);
    chk("jalr_mis_cnt", BRU_o_mis_cnt, 32'd2);
    chk("jalr_br_cnt", BRU_o_br_cnt, 32'd4);
    finish_redirect("jalr");

    // Three taken beq at 0x40, predicted not taken
    IFU_i_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      br(3'b000, 0, 0, 32'h40, 32'h80, 0, 1, 0);
      if (k == 0) chk("bht_same_cycle_old", {31'd0, IFU_o_pred_taken}, 32'd0);
      tick(); EXU_i_valid = 1'b0; #1;
      chk("bht_taken_pred", {31'd0, IFU_o_pred_taken}, 32'd1);
      finish_redirect("bht40");
    end
    chk("bht40_br_cnt", BRU_o_br_cnt, 32'd7);
    chk("bht40_mis_cnt", BRU_o_mis_cnt, 32'd5);
    // Two not-taken, correctly predicted: 11 -> 10 -> 01 proves saturation
    br(3'b000, 0, 0, 32'h40, 32'h80, 0, 0, 0);
    tick();
    chk("bht_sat_10", {31'd0, IFU_o_pred_taken}, 32'd1);
    chk("bht_nt_no_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    tick(); EXU_i_valid = 1'b0; #1;
    chk("bht_sat_01", {31'd0, IFU_o_pred_taken}, 32'd0);
    chk("bht_nt_br_cnt", BRU_o_br_cnt, 32'd9);
    chk("bht_nt_mis_cnt", BRU_o_mis_cnt, 32'd5);

    // Redirect held with ready low, then reset from REDIRECT
    br(3'b001, 0, 0, 32'h500, 32'h600, 0, 0, 0);
    tick();
    br(3'b000, 0, 0, 32'h504, 32'h999, 0, 1, 0);      // must not be accepted
    for (int k = 0; k < 5; k++) begin
      chk("hold_rv", {31'd0, IFU_o_redirect_valid}, 32'd1);
      chk("hold_rpc", IFU_o_redirect_pc, 32'h600);
      chk("hold_ready", {31'd0, EXU_o_ready}, 32'd0);
      tick();
    end
    chk("hold_br_cnt", BRU_o_br_cnt, 32'd10);
    chk("hold_mis_cnt", BRU_o_mis_cnt, 32'd6);
    EXU_i_valid = 1'b0; IFU_i_redirect_ready = 1'b1; rst_n = 1'b0;
    IFU_i_pc = 32'h100;
    tick();
    chk("rst2_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("rst2_flush", {31'd0, BRU_o_flush}, 32'd0);
    chk("rst2_br_cnt", BRU_o_br_cnt, 32'd0);
    chk("rst2_mis_cnt", BRU_o_mis_cnt, 32'd0);
    chk("rst2_rpc", IFU_o_redirect_pc, 32'd0);
    chk("rst2_bht", {31'd0, IFU_o_pred_taken}, 32'd0);
    IFU_i_redirect_ready = 1'b0; rst_n = 1'b1; #1;
    chk("rst2_ready", {31'd0, EXU_o_ready}, 32'd1);

    // Illegal funct3 010: no effect
    IFU_i_pc = 32'h700;
    br(3'b010, 0, 0, 32'h700, 32'h740, 0, 1, 0);
    tick(); EXU_i_valid = 1'b0; #1;
    chk("ill_br_cnt", BRU_o_br_cnt, 32'd0);
    chk("ill_mis_cnt", BRU_o_mis_cnt, 32'd0);
    chk("ill_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("ill_taken", {31'd0, BRU_o_taken}, 32'd0);
    chk("ill_bht", {31'd0, IFU_o_pred_taken}, 32'd0);

    // pc+4 wrap on a not-taken mispredict
    br(3'b000, 0, 0, 32'hFFFF_FFFC, 32'h40, 1, 0, 0);
    tick(); EXU_i_valid = 1'b0;
    chk("wrap_rv", {31'd0, IFU_o_redirect_valid}, 32'd1);
    chk("wrap_rpc", IFU_o_redirect_pc, 32'h0);
    chk("wrap_mis_cnt", BRU_o_mis_cnt, 32'd1);
    finish_redirect("wrap");

    // JAL predicted taken, funct3 ignored: no redirect
    br(3'b010, 1, 1, 32'h800, 32'h901, 1, 0, 0);
    tick(); EXU_i_valid = 1'b0; #1;
    chk("jal_rv", {31'd0, IFU_o_redirect_valid}, 32'd0);
    chk("jal_taken", {31'd0, BRU_o_taken}, 32'd1);
    chk("jal_br_cnt", BRU_o_br_cnt, 32'd2);
    chk("jal_mis_cnt", BRU_o_mis_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
